// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// Button front end and mode sequencer for setting a seconds-of-day clock
// and its alarm. Each raw button goes through a 2-flop synchronizer and a
// debouncer. Rising debounced edges become press events. The hour and
// minute buttons auto-repeat while held in the two edit modes.
//
// Ports
//   clock          single clock, posedge
//   reset          synchronous, active-high
//   btn_mode       raw mode button, high = pressed
//   btn_hour       raw hour button, high = pressed
//   btn_min        raw minute button, high = pressed
//   counter_state  current seconds-of-day (0..86399)
//   set_flag       high while in SET_CLOCK; holds the time counter at set_time
//   set_time       seconds-of-day to load into the time counter
//   alarm_flag     alarm armed
//   alarm_time     alarm setpoint, seconds-of-day
//   mode_state     0 = RUN, 1 = SET_CLOCK, 2 = SET_ALARM
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal timekeeping; hour press toggles alarm_flag
// SET_CLOCK | set_flag high, hour/min edit set_time
// SET_ALARM | alarm disarmed, hour/min edit alarm_time

module time_set_ctrl #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 8,
    parameter int REPEAT_RATE    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_hour,
    input  logic        btn_min,
    input  logic [16:0] counter_state,
    output logic        set_flag,
    output logic [16:0] set_time,
    output logic        alarm_flag,
    output logic [16:0] alarm_time,
    output logic [1:0]  mode_state
);

    localparam int DBW     = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW     = $clog2(RPT_MAX + 1);

    localparam logic [DBW-1:0] DB_LOAD  = DBW'(DEBOUNCE_TICKS);
    localparam logic [RPW-1:0] RD_LOAD  = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] RR_LOAD  = RPW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_CLOCK = 2'd1,
        SET_ALARM = 2'd2
    } mode_t;

    // bit 0 = mode, bit 1 = hour, bit 2 = minute
    logic [2:0]     raw;
    logic [2:0]     sync1, sync2, deb;
    logic [DBW-1:0] db_cnt [3];
    logic [2:0]     lock;
    logic [1:0]     rdy;

    logic [2:0]     differ, flip, rise, fall, press;

    logic [1:0]     arm;
    logic [RPW-1:0] rpt_cnt [2];
    logic [1:0]     rpt_ev;

    logic           mode_ev, hour_ev, min_ev, hour_press;

    mode_t          state_q, state_d;
    logic [16:0]    set_time_d, alarm_time_d;
    logic           alarm_flag_d;

    assign raw = {btn_min, btn_hour, btn_mode};

    // The debounce timer counts down from DEBOUNCE_TICKS while the
    // synchronized level differs from the debounced level.
    // The level flips on the sample that finds the timer already at zero,
    // so DEBOUNCE_TICKS+1 consecutive differing samples are needed.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            differ[i] = sync2[i] ^ deb[i];
            flip[i]   = differ[i] && (db_cnt[i] == '0);
            rise[i]   = flip[i] && !deb[i];
            fall[i]   = flip[i] && deb[i];
            // A button held through reset stays locked until it has been
            // seen released, so it cannot produce an event.
            press[i]  = rise[i] && !lock[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            lock  <= '1;
            rdy   <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= DB_LOAD;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // rdy[1] marks that sync2 now carries a post-reset sample.
            rdy   <= {rdy[0], 1'b1};
            for (int i = 0; i < 3; i++) begin
                if (!differ[i] || flip[i])
                    db_cnt[i] <= DB_LOAD;
                else
                    db_cnt[i] <= db_cnt[i] - 1'b1;
                if (flip[i])
                    deb[i] <= ~deb[i];
                if (rdy[1] && !sync2[i])
                    lock[i] <= 1'b0;
            end
        end
    end

    // Auto-repeat for hour (index 0) and minute (index 1). The repeat
    // timer is armed only by a genuine press event. The cycle in which the
    // debounced level drops does not count as held.
    always_comb begin
        for (int j = 0; j < 2; j++)
            rpt_ev[j] = arm[j] && deb[j+1] && !fall[j+1] && (rpt_cnt[j] == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            arm <= '0;
            for (int j = 0; j < 2; j++) rpt_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (press[j+1]) begin
                    arm[j]     <= 1'b1;
                    rpt_cnt[j] <= RD_LOAD;
                end else if (!arm[j] || !deb[j+1] || fall[j+1]) begin
                    arm[j]     <= 1'b0;
                    rpt_cnt[j] <= '0;
                end else if (rpt_cnt[j] == '0) begin
                    rpt_cnt[j] <= RR_LOAD;
                end else begin
                    rpt_cnt[j] <= rpt_cnt[j] - 1'b1;
                end
            end
        end
    end

    assign mode_ev    = press[0];
    assign hour_press = press[1];
    assign hour_ev    = press[1] | rpt_ev[0];
    assign min_ev     = press[2] | rpt_ev[1];

    function automatic logic [16:0] add_hour(input logic [16:0] t);
        logic [16:0] s;
        s = t + 17'd3600;
        if (s >= 17'd86400)
            s = s - 17'd86400;
        return s;
    endfunction

    // Minute field wraps 59 -> 0 without carrying into the hour.
    function automatic logic [16:0] add_min(input logic [16:0] t);
        logic [16:0] m;
        m = (t / 17'd60) % 17'd60;
        if (m == 17'd59)
            return t - 17'd3540;
        return t + 17'd60;
    endfunction

    function automatic logic [16:0] edit(input logic [16:0] t,
                                         input logic h, input logic m);
        logic [16:0] r;
        r = t;
        if (h) r = add_hour(r);
        if (m) r = add_min(r);
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        set_time_d   = set_time;
        alarm_time_d = alarm_time;
        alarm_flag_d = alarm_flag;
        case (state_q)
            RUN: begin
                if (mode_ev) begin
                    state_d    = SET_CLOCK;
                    set_time_d = counter_state - (counter_state % 17'd60);
                end else if (hour_press) begin
                    alarm_flag_d = ~alarm_flag;
                end
            end
            SET_CLOCK: begin
                if (mode_ev) begin
                    state_d      = SET_ALARM;
                    alarm_flag_d = 1'b0;
                end else begin
                    set_time_d = edit(set_time, hour_ev, min_ev);
                end
            end
            SET_ALARM: begin
                alarm_flag_d = 1'b0;
                if (mode_ev) begin
                    state_d      = RUN;
                    alarm_flag_d = 1'b1;
                end else begin
                    alarm_time_d = edit(alarm_time, hour_ev, min_ev);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            set_flag   <= 1'b0;
            set_time   <= '0;
            alarm_flag <= 1'b0;
            alarm_time <= '0;
        end else begin
            state_q    <= state_d;
            set_flag   <= (state_d == SET_CLOCK);
            set_time   <= set_time_d;
            alarm_flag <= alarm_flag_d;
            alarm_time <= alarm_time_d;
        end
    end

    assign mode_state = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        btn_mode, btn_hour, btn_min;
   logic [16:0] counter_state;
   logic        set_flag;
   logic [16:0] set_time;
   logic        alarm_flag;
   logic [16:0] alarm_time;
   logic [1:0]  mode_state;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [1:0]  mode;
      logic        sf;
      logic [16:0] st;
      logic        af;
      logic [16:0] at;
   } exp_t;

   exp_t sb_q[$];

   time_set_ctrl #(
      .DEBOUNCE_TICKS(4),
      .REPEAT_DELAY(8),
      .REPEAT_RATE(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .btn_mode(btn_mode),
      .btn_hour(btn_hour),
      .btn_min(btn_min),
      .counter_state(counter_state),
      .set_flag(set_flag),
      .set_time(set_time),
      .alarm_flag(alarm_flag),
      .alarm_time(alarm_time),
      .mode_state(mode_state)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic push_exp(input string n, input logic [1:0] m, input logic sf,
                           input logic [16:0] st, input logic af, input logic [16:0] at);
      exp_t e;
      e.name = n; e.mode = m; e.sf = sf; e.st = st; e.af = af; e.at = at;
      sb_q.push_back(e);
   endtask

   // mask bit 0 = mode, 1 = hour, 2 = minute
   task automatic press_mask(input logic [2:0] m, input int hold);
      btn_mode = m[0];
      btn_hour = m[1];
      btn_min  = m[2];
      tick(hold);
      btn_mode = 1'b0;
      btn_hour = 1'b0;
      btn_min  = 1'b0;
      tick(12);
   endtask

   task automatic do_reset(input logic [16:0] cs);
      counter_state = cs;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(4);
   endtask

   // Monitor: drains the scoreboard on each falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (mode_state !== e.mode || set_flag !== e.sf || set_time !== e.st ||
                alarm_flag !== e.af || alarm_time !== e.at) begin
               bad++;
               $display("FAIL %s: got mode=%0d set_flag=%0b set_time=%0d alarm_flag=%0b alarm_time=%0d, want mode=%0d set_flag=%0b set_time=%0d alarm_flag=%0b alarm_time=%0d",
                        e.name, mode_state, set_flag, set_time, alarm_flag, alarm_time,
                        e.mode, e.sf, e.st, e.af, e.at);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      btn_mode = 1'b0;
      btn_hour = 1'b0;
      btn_min  = 1'b0;
      counter_state = 17'd34953;
      reset = 1'b1;
      tick(3);
      push_exp("reset_state", 2'd0, 1'b0, 17'd0, 1'b0, 17'd0);
      reset = 1'b0;
      tick(4);

      press_mask(3'b001, 10);
      push_exp("enter_set_clock", 2'd1, 1'b1, 17'd34920, 1'b0, 17'd0);
      total++;
      if (mode_state !== 2'd1 || set_time !== 17'd34920) begin
         bad++;
         $display("FAIL direct_enter_set_clock: mode=%0d set_time=%0d", mode_state, set_time);
      end

      press_mask(3'b010, 3);
      push_exp("short_hour_ignored", 2'd1, 1'b1, 17'd34920, 1'b0, 17'd0);

      // Raw hour first sampled at edge k, held 6 cycles.
      btn_hour = 1'b1;
      tick(6);
      push_exp("hour_before_k6", 2'd1, 1'b1, 17'd34920, 1'b0, 17'd0);
      btn_hour = 1'b0;
      tick(1);
      push_exp("hour_at_k6", 2'd1, 1'b1, 17'd38520, 1'b0, 17'd0);
      total++;
      if (set_time !== 17'd38520) begin
         bad++;
         $display("FAIL direct_hour_at_k6: set_time=%0d", set_time);
      end
      tick(12);

      do_reset(17'd84630);
      press_mask(3'b001, 6);
      push_exp("load_84600", 2'd1, 1'b1, 17'd84600, 1'b0, 17'd0);
      press_mask(3'b010, 6);
      push_exp("hour_wrap", 2'd1, 1'b1, 17'd1800, 1'b0, 17'd0);

      do_reset(17'd35959);
      press_mask(3'b001, 6);
      push_exp("load_35940", 2'd1, 1'b1, 17'd35940, 1'b0, 17'd0);
      press_mask(3'b100, 6);
      push_exp("min_wrap", 2'd1, 1'b1, 17'd32400, 1'b0, 17'd0);
      press_mask(3'b110, 6);
      push_exp("hour_then_min", 2'd1, 1'b1, 17'd36060, 1'b0, 17'd0);

      do_reset(17'd59);
      press_mask(3'b001, 6);
      push_exp("load_zero", 2'd1, 1'b1, 17'd0, 1'b0, 17'd0);
      press_mask(3'b100, 20);
      push_exp("min_repeat_7", 2'd1, 1'b1, 17'd420, 1'b0, 17'd0);

      press_mask(3'b011, 6);
      push_exp("mode_discards_edit", 2'd2, 1'b0, 17'd420, 1'b0, 17'd0);
      press_mask(3'b010, 6);
      push_exp("alarm_hour", 2'd2, 1'b0, 17'd420, 1'b0, 17'd3600);
      press_mask(3'b100, 6);
      push_exp("alarm_min", 2'd2, 1'b0, 17'd420, 1'b0, 17'd3660);
      press_mask(3'b001, 6);
      push_exp("to_run_armed", 2'd0, 1'b0, 17'd420, 1'b1, 17'd3660);
      total++;
      if (alarm_flag !== 1'b1 || mode_state !== 2'd0) begin
         bad++;
         $display("FAIL direct_to_run_armed: mode=%0d alarm_flag=%0b", mode_state, alarm_flag);
      end
      press_mask(3'b010, 6);
      push_exp("run_hour_toggle", 2'd0, 1'b0, 17'd420, 1'b0, 17'd3660);
      press_mask(3'b100, 6);
      push_exp("run_min_ignored", 2'd0, 1'b0, 17'd420, 1'b0, 17'd3660);
      press_mask(3'b010, 20);
      push_exp("run_hour_no_repeat", 2'd0, 1'b0, 17'd420, 1'b1, 17'd3660);

      press_mask(3'b001, 6);
      press_mask(3'b001, 6);
      push_exp("enter_alarm_again", 2'd2, 1'b0, 17'd0, 1'b0, 17'd3660);

      btn_hour = 1'b1;
      tick(10);
      reset = 1'b1;
      tick(2);
      push_exp("reset_mid_edit", 2'd0, 1'b0, 17'd0, 1'b0, 17'd0);
      total++;
      if (mode_state !== 2'd0 || alarm_time !== 17'd0) begin
         bad++;
         $display("FAIL direct_reset_mid_edit: mode=%0d alarm_time=%0d", mode_state, alarm_time);
      end
      reset = 1'b0;
      tick(20);
      push_exp("held_no_event", 2'd0, 1'b0, 17'd0, 1'b0, 17'd0);
      btn_mode = 1'b1;
      tick(6);
      btn_mode = 1'b0;
      tick(12);
      push_exp("held_in_set_clock", 2'd1, 1'b1, 17'd0, 1'b0, 17'd0);
      btn_hour = 1'b0;
      tick(12);
      push_exp("released_no_event", 2'd1, 1'b1, 17'd0, 1'b0, 17'd0);
      press_mask(3'b010, 6);
      push_exp("repress_hour", 2'd1, 1'b1, 17'd3600, 1'b0, 17'd0);

      @(negedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      if (bad == 0 && total > 0)
         $display("PASS");
      else
         $display("FAIL");
      $finish;
   end

endmodule
